spi_fsm: RTL

Transaction controller for the SPI peripheral: sequences the shared 8-bit shift register, address latch, data memory write port and MISO tri-state buffer across one chip-select-framed transfer. Consumes conditioned chip select and single-cycle serial-clock edge pulses from the input conditioners. Emits one-cycle control strobes to the datapath. Each transfer is one address/R-W byte followed by one data byte, read or write.

---
 rtl/spi_fsm.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_fsm.sv
// Transfer sequencer for the SPI peripheral: one address/R-W byte, then one data byte.
// Define SPI_FSM_ABORT_EN to let chip-select deassertion abort a transfer in progress.
module spi_fsm #(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cs,
    input  logic            sclk_pos,
    input  logic            sclk_neg,
    input  logic [BITS-1:0] sr_out,
    output logic            addr_we,
    output logic            sr_we,
    output logic            dm_we,
    output logic            miso_buff,
    output logic            busy
);

    localparam int unsigned CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_GET_ADDR    = 3'd1;
    localparam logic [2:0] S_GOT_ADDR    = 3'd2;
    localparam logic [2:0] S_READ_LOAD   = 3'd3;
    localparam logic [2:0] S_READ_SEND   = 3'd4;
    localparam logic [2:0] S_WRITE_GET   = 3'd5;
    localparam logic [2:0] S_WRITE_STORE = 3'd6;
    localparam logic [2:0] S_DONE        = 3'd7;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_addr_we;
    logic          r_sr_we;
    logic          r_dm_we;
    logic          r_miso_buff;
    logic          r_busy;

    // Only the R/W bit of the shift register matters to sequencing.
    logic w_unused_sr;
    assign w_unused_sr = ^sr_out[BITS-1:1];

    // State, counter and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr_we   <= 1'b0;
            r_sr_we     <= 1'b0;
            r_dm_we     <= 1'b0;
            r_miso_buff <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr_we   <= (w_state_nxt == S_GOT_ADDR);
            r_sr_we     <= (w_state_nxt == S_READ_LOAD);
            r_dm_we     <= (w_state_nxt == S_WRITE_STORE);
            r_miso_buff <= (w_state_nxt == S_READ_SEND);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!cs) begin
                    w_state_nxt = S_GET_ADDR;
                    w_cnt_nxt   = '0;
                end
            end
            S_GET_ADDR: begin
                if (sclk_pos) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == LAST) w_state_nxt = S_GOT_ADDR;
                end
            end
            S_GOT_ADDR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = sr_out[0] ? S_READ_LOAD : S_WRITE_GET;
            end
            S_READ_LOAD: w_state_nxt = S_READ_SEND;
            S_READ_SEND: begin
                if (sclk_neg) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == LAST) w_state_nxt = S_DONE;
                end
            end
            S_WRITE_GET: begin
                if (sclk_pos) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == LAST) w_state_nxt = S_WRITE_STORE;
                end
            end
            S_WRITE_STORE: w_state_nxt = S_DONE;
            S_DONE: begin
                if (cs) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
`ifdef SPI_FSM_ABORT_EN
        // Chip-select release overrides everything, including a final counted pulse.
        if (cs && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
`endif
    end

    assign addr_we   = r_addr_we;
    assign sr_we     = r_sr_we;
    assign dm_we     = r_dm_we;
    assign miso_buff = r_miso_buff;
    assign busy      = r_busy;

endmodule
